// File: rtl/parking_pkg.sv
// Shared definitions for the parking controller tick scheduler: config FSM
// state encoding, default clock rate, divisor width and the standard channel
// divisors used with a 1 kHz base tick.
package parking_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_PENDING = 2'd1,
        ST_APPLY   = 2'd2
    } tick_state_e;

    localparam int CLK_HZ = 40_000_000;
    localparam int DIV_W  = 16;

    // Divisors for common rates, assuming BASE_HZ = 1000.
    localparam int DIV_500HZ = 2;
    localparam int DIV_50HZ  = 20;
    localparam int DIV_4HZ   = 250;
    localparam int DIV_2HZ   = 500;
    localparam int DIV_1HZ   = 1000;

endpackage

// File: rtl/tick_channel.sv
// One scheduler channel: divisor/enable registers, base-tick counter and the
// registered tick pulse plus 50% level output. A write restarts the phase and
// swallows any terminal count that lands in the same cycle.
// Optional feature macro: ALIGN_EN (adds align_i, a synchronous phase clear).
module tick_channel #(
    parameter int DIV_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             base_tick_i,
    input  logic             wr_i,
    input  logic             wr_en_i,
    input  logic [DIV_W-1:0] wr_div_i,
`ifdef ALIGN_EN
    input  logic             align_i,
`endif
    output logic             tick_o,
    output logic             level_o,
    output logic             active_o
);

    logic             en_q, en_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic [DIV_W-1:0] cnt_q, cnt_d;
    logic             tick_q, tick_d;
    logic             level_q, level_d;
    logic             active;

    // A divisor of zero parks the channel even when enabled.
    assign active = en_q && (div_q != '0);

    // Next state: write beats align, align beats counting, idle channels hold zero.
    always_comb begin
        en_d    = en_q;
        div_d   = div_q;
        cnt_d   = cnt_q;
        tick_d  = 1'b0;
        level_d = level_q;
        if (wr_i) begin
            en_d    = wr_en_i;
            div_d   = wr_div_i;
            cnt_d   = '0;
            level_d = 1'b0;
        end
`ifdef ALIGN_EN
        else if (align_i) begin
            cnt_d   = '0;
            level_d = 1'b0;
        end
`endif
        else if (!active) begin
            cnt_d   = '0;
            level_d = 1'b0;
        end else if (base_tick_i) begin
            // div >= 1 here, so div-1 cannot wrap.
            if (cnt_q == div_q - DIV_W'(1)) begin
                cnt_d   = '0;
                tick_d  = 1'b1;
                level_d = ~level_q;
            end else begin
                cnt_d = cnt_q + DIV_W'(1);
            end
        end
    end

    // Channel registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            en_q    <= 1'b0;
            div_q   <= '0;
            cnt_q   <= '0;
            tick_q  <= 1'b0;
            level_q <= 1'b0;
        end else begin
            en_q    <= en_d;
            div_q   <= div_d;
            cnt_q   <= cnt_d;
            tick_q  <= tick_d;
            level_q <= level_d;
        end
    end

    assign tick_o   = tick_q;
    assign level_o  = level_q;
    assign active_o = active;

endmodule

// File: rtl/tick_rate_scheduler.sv
// Shared programmable tick generator. A prescaler turns clk into a base tick
// at BASE_HZ; NUM_CH tick_channel instances divide it further. Channel
// configs arrive over a valid/ready port and are committed only on a base
// tick edge so outputs never glitch.
// Handshake: a request transfers on the rising edge where cfg_valid and
// cfg_ready are both high; cfg_ready is registered and drops for the whole
// time an update is in flight, so the requester must hold cfg_valid and its
// payload until it sees cfg_ready high.
// Optional feature macro: ALIGN_EN (adds the align input, which restarts the
// prescaler and all channel phases and flushes any pending update).
module tick_rate_scheduler #(
    parameter int CLK_HZ  = parking_pkg::CLK_HZ,
    parameter int BASE_HZ = 1000,
    parameter int NUM_CH  = 4,
    parameter int DIV_W   = parking_pkg::DIV_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    input  logic [2:0]        cfg_ch,
    input  logic              cfg_en,
    input  logic [DIV_W-1:0]  cfg_div,
    output logic              base_tick,
    output logic [NUM_CH-1:0] ch_tick,
    output logic [NUM_CH-1:0] ch_level,
    output logic [NUM_CH-1:0] ch_active
`ifdef ALIGN_EN
    ,
    input  logic              align
`endif
);

    import parking_pkg::*;

    localparam int PRESCALE = CLK_HZ / BASE_HZ;
    localparam int PW       = (PRESCALE < 2) ? 1 : $clog2(PRESCALE);

    if (PRESCALE < 2 || (CLK_HZ % BASE_HZ) != 0) begin : g_bad_prescale
        $error("tick_rate_scheduler: CLK_HZ/BASE_HZ must be an integer >= 2");
    end
    if (NUM_CH < 1 || NUM_CH > 8) begin : g_bad_num_ch
        $error("tick_rate_scheduler: NUM_CH must be in 1..8");
    end

    logic [PW-1:0]    presc_q, presc_d;
    logic             base_tick_q, base_tick_d;

    tick_state_e      state_q;
    logic             cfg_ready_q;
    logic [2:0]       pend_ch_q;
    logic             pend_en_q;
    logic [DIV_W-1:0] pend_div_q;
    logic             apply;

    // Prescaler next state: wrap at PRESCALE-1 and raise the base tick.
    always_comb begin
        presc_d     = presc_q + PW'(1);
        base_tick_d = 1'b0;
        if (presc_q == PW'(PRESCALE - 1)) begin
            presc_d     = '0;
            base_tick_d = 1'b1;
        end
`ifdef ALIGN_EN
        if (align) begin
            presc_d     = '0;
            base_tick_d = 1'b0;
        end
`endif
    end

    // Prescaler registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            presc_q     <= '0;
            base_tick_q <= 1'b0;
        end else begin
            presc_q     <= presc_d;
            base_tick_q <= base_tick_d;
        end
    end

    // The pending write lands on the same edge the FSM enters APPLY, so the
    // new settings are visible (and the tick suppressed) during APPLY.
`ifdef ALIGN_EN
    assign apply = (state_q == ST_PENDING) && (base_tick_q || align);
`else
    assign apply = (state_q == ST_PENDING) && base_tick_q;
`endif

    // Config FSM with registered cfg_ready; one update in flight at most.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            cfg_ready_q <= 1'b1;
            pend_ch_q   <= '0;
            pend_en_q   <= 1'b0;
            pend_div_q  <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (cfg_valid && cfg_ready_q) begin
                        pend_ch_q   <= cfg_ch;
                        pend_en_q   <= cfg_en;
                        pend_div_q  <= cfg_div;
                        state_q     <= ST_PENDING;
                        cfg_ready_q <= 1'b0;
                    end
                end
                ST_PENDING: begin
`ifdef ALIGN_EN
                    if (align) begin
                        state_q     <= ST_IDLE;
                        cfg_ready_q <= 1'b1;
                    end else
`endif
                    if (base_tick_q) begin
                        state_q <= ST_APPLY;
                    end
                end
                ST_APPLY: begin
                    state_q     <= ST_IDLE;
                    cfg_ready_q <= 1'b1;
                end
                default: begin
                    state_q     <= ST_IDLE;
                    cfg_ready_q <= 1'b1;
                end
            endcase
        end
    end

    // Channel bank; out-of-range targets match no channel and change nothing.
    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        tick_channel #(
            .DIV_W(DIV_W)
        ) u_ch (
            .clk        (clk),
            .reset      (reset),
            .base_tick_i(base_tick_q),
            .wr_i       (apply && (pend_ch_q == 3'(c))),
            .wr_en_i    (pend_en_q),
            .wr_div_i   (pend_div_q),
`ifdef ALIGN_EN
            .align_i    (align),
`endif
            .tick_o     (ch_tick[c]),
            .level_o    (ch_level[c]),
            .active_o   (ch_active[c])
        );
    end

    assign base_tick = base_tick_q;
    assign cfg_ready = cfg_ready_q;

endmodule

// File: tb/tb_tick_rate_scheduler.sv
// Directed bench for tick_rate_scheduler at CLK_HZ=100, BASE_HZ=10
// (PRESCALE=10), NUM_CH=4. Cycle n is the interval after the n-th rising
// edge following reset release; outputs are sampled 1 time unit after the edge.
// Expected ch_tick per cycle comes from a hand-built table; base_tick is
// expected every 10 cycles from base_phase.
module tb_tick_rate_scheduler;

  localparam int NUM_CH = 4;
  localparam int DIV_W  = 16;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              cfg_valid = 1'b0;
  logic              cfg_ready;
  logic [2:0]        cfg_ch = 3'd0;
  logic              cfg_en = 1'b0;
  logic [DIV_W-1:0]  cfg_div = '0;
  logic              base_tick;
  logic [NUM_CH-1:0] ch_tick;
  logic [NUM_CH-1:0] ch_level;
  logic [NUM_CH-1:0] ch_active;
`ifdef ALIGN_EN
  logic              align = 1'b0;
`endif

  int cyc = 0;
  int n_checks = 0;
  int n_errors = 0;
  int base_phase = 0;
  logic [NUM_CH-1:0] exp_tick [0:255];

  tick_rate_scheduler #(
    .CLK_HZ (100),
    .BASE_HZ(10),
    .NUM_CH (NUM_CH),
    .DIV_W  (DIV_W)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .cfg_valid(cfg_valid),
    .cfg_ready(cfg_ready),
    .cfg_ch   (cfg_ch),
    .cfg_en   (cfg_en),
    .cfg_div  (cfg_div),
    .base_tick(base_tick),
    .ch_tick  (ch_tick),
    .ch_level (ch_level),
    .ch_active(ch_active)
`ifdef ALIGN_EN
    ,
    .align    (align)
`endif
  );

  // clock / cycle counter
  always #5 clk = ~clk;

  always @(posedge clk or posedge reset) begin
    if (reset) cyc <= 0;
    else       cyc <= cyc + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s cycle %0d: got %0h expected %0h", tag, cyc, got, exp);
    end
  endtask

  // advance one cycle and check the per-cycle pulse outputs
  task automatic step();
    logic exp_base;
    @(posedge clk);
    #1;
    exp_base = (cyc > base_phase) && (((cyc - base_phase) % 10) == 0);
    check("base_tick", 32'(base_tick), 32'(exp_base));
    if (cyc < 256) check("ch_tick", 32'(ch_tick), 32'(exp_tick[cyc]));
  endtask

  task automatic run_to(input int n);
    for (int k = 0; k < 300 && cyc < n; k++) step();
    check("run_to", cyc, n);
  endtask

  task automatic drive(input logic [2:0] ch, input logic en, input logic [DIV_W-1:0] div);
    cfg_valid = 1'b1;
    cfg_ch    = ch;
    cfg_en    = en;
    cfg_div   = div;
  endtask

  task automatic clear_exp();
    for (int i = 0; i < 256; i++) exp_tick[i] = '0;
  endtask

  initial begin
    clear_exp();
    // ch0 div3 from APPLY@11: ticks 41, 71; 101 swallowed by reconfig to div5 -> 151
    exp_tick[41][0] = 1'b1;
    exp_tick[71][0] = 1'b1;
    exp_tick[151][0] = 1'b1;
    // ch1 div1 from APPLY@21: every base tick + 1
    for (int t = 31; t <= 161; t += 10) exp_tick[t][1] = 1'b1;
    // ch3 div2 from APPLY@111
    exp_tick[131][3] = 1'b1;
    exp_tick[151][3] = 1'b1;

    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    // reset state
    check("rst_ready", 32'(cfg_ready), 32'h1);
    check("rst_base", 32'(base_tick), 32'h0);
    check("rst_tick", 32'(ch_tick), 32'h0);
    check("rst_level", 32'(ch_level), 32'h0);
    check("rst_active", 32'(ch_active), 32'h0);

    // ch0 div=3 requested at cycle 2
    run_to(2);
    check("ready_c2", 32'(cfg_ready), 32'h1);
    drive(3'd0, 1'b1, 16'd3);
    run_to(3);
    cfg_valid = 1'b0;
    check("ready_c3", 32'(cfg_ready), 32'h0);
    run_to(10);
    check("ready_c10", 32'(cfg_ready), 32'h0);
    check("active_c10", 32'(ch_active), 32'h0);
    run_to(11);
    check("ready_c11", 32'(cfg_ready), 32'h0);
    check("active_c11", 32'(ch_active), 32'h1);

    // ch1 div=1
    run_to(12);
    check("ready_c12", 32'(cfg_ready), 32'h1);
    drive(3'd1, 1'b1, 16'd1);
    run_to(13);
    cfg_valid = 1'b0;
    check("ready_c13", 32'(cfg_ready), 32'h0);
    run_to(21);
    check("active_c21", 32'(ch_active), 32'h3);

    // ch2 enabled with div=0 stays inactive
    run_to(22);
    check("ready_c22", 32'(cfg_ready), 32'h1);
    drive(3'd2, 1'b1, 16'd0);
    run_to(23);
    cfg_valid = 1'b0;
    run_to(32);
    check("ready_c32", 32'(cfg_ready), 32'h1);
    check("active_c32", 32'(ch_active), 32'h3);
    run_to(41);
    check("level0_c41", 32'(ch_level[0]), 32'h1);
    run_to(60);
    check("level_c60", 32'(ch_level), 32'h3);
    run_to(71);
    check("level0_c71", 32'(ch_level[0]), 32'h0);

    // reconfigure ch0 to div5 so APPLY lands on its terminal count at 101;
    // a second request (ch3) is held through PENDING
    run_to(92);
    drive(3'd0, 1'b1, 16'd5);
    run_to(93);
    check("ready_c93", 32'(cfg_ready), 32'h0);
    drive(3'd3, 1'b1, 16'd2);
    run_to(100);
    check("ready_c100", 32'(cfg_ready), 32'h0);
    check("level_c100", 32'(ch_level), 32'h2);
    run_to(101);
    check("ready_c101", 32'(cfg_ready), 32'h0);
    check("level_c101", 32'(ch_level), 32'h0);
    check("active_c101", 32'(ch_active), 32'h3);
    run_to(102);
    check("ready_c102", 32'(cfg_ready), 32'h1);
    run_to(103);
    check("ready_c103", 32'(cfg_ready), 32'h0);
    cfg_valid = 1'b0;
    run_to(110);
    check("active_c110", 32'(ch_active), 32'h3);
    run_to(111);
    check("active_c111", 32'(ch_active), 32'hb);
    check("level1_c111", 32'(ch_level[1]), 32'h1);

    // out-of-range channel completes the handshake with no effect
    run_to(112);
    check("ready_c112", 32'(cfg_ready), 32'h1);
    drive(3'd6, 1'b1, 16'd7);
    run_to(113);
    cfg_valid = 1'b0;
    check("ready_c113", 32'(cfg_ready), 32'h0);
    run_to(122);
    check("ready_c122", 32'(cfg_ready), 32'h1);
    check("active_c122", 32'(ch_active), 32'hb);
    run_to(151);
    check("level_c151", 32'(ch_level), 32'h3);

    // reset while an update for ch2 (div1) is pending
    run_to(162);
    drive(3'd2, 1'b1, 16'd1);
    run_to(163);
    cfg_valid = 1'b0;
    check("ready_c163", 32'(cfg_ready), 32'h0);
    run_to(165);
    check("level_pre_rst", 32'(ch_level), 32'h1);
    reset = 1'b1;
    #1;
    check("midrst_ready", 32'(cfg_ready), 32'h1);
    check("midrst_level", 32'(ch_level), 32'h0);
    check("midrst_active", 32'(ch_active), 32'h0);
    check("midrst_tick", 32'(ch_tick), 32'h0);
    check("midrst_base", 32'(base_tick), 32'h0);
    clear_exp();
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    run_to(40);
    check("post_rst_active", 32'(ch_active), 32'h0);
    check("post_rst_level", 32'(ch_level), 32'h0);
    check("post_rst_ready", 32'(cfg_ready), 32'h1);

`ifdef ALIGN_EN
    // ch0/ch1 both div2 but applied one base tick apart, then realigned
    exp_tick[71] = 4'b0001;
    exp_tick[97] = 4'b0011;
    exp_tick[117] = 4'b0011;
    run_to(42);
    drive(3'd0, 1'b1, 16'd2);
    run_to(43);
    cfg_valid = 1'b0;
    run_to(52);
    check("al_ready_c52", 32'(cfg_ready), 32'h1);
    drive(3'd1, 1'b1, 16'd2);
    run_to(53);
    cfg_valid = 1'b0;
    run_to(75);
    check("al_level_c75", 32'(ch_level), 32'h1);
    align = 1'b1;
    base_phase = 76;
    run_to(76);
    align = 1'b0;
    check("al_level_c76", 32'(ch_level), 32'h0);
    run_to(97);
    check("al_level_c97", 32'(ch_level), 32'h3);
    run_to(120);
`endif

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
